// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS control unit.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_WIDTH   = 6;
    localparam int unsigned FUNCT_WIDTH    = 6;
    localparam int unsigned ALU_CMD_WIDTH  = 2;
    localparam int unsigned HILO_SEL_WIDTH = 2;
    localparam int unsigned MULT_CNT_WIDTH = 8;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction bits [5:0])
    localparam logic [FUNCT_WIDTH-1:0] FN_JR   = 6'h08;
    localparam logic [FUNCT_WIDTH-1:0] FN_MFHI = 6'h10;
    localparam logic [FUNCT_WIDTH-1:0] FN_MFLO = 6'h12;
    localparam logic [FUNCT_WIDTH-1:0] FN_MULT = 6'h18;
    localparam logic [FUNCT_WIDTH-1:0] FN_ADD  = 6'h20;
    localparam logic [FUNCT_WIDTH-1:0] FN_SUB  = 6'h22;
    localparam logic [FUNCT_WIDTH-1:0] FN_SLT  = 6'h2A;

    typedef enum logic [ALU_CMD_WIDTH-1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_XOR = 2'd2,
        ALU_SLT = 2'd3
    } alu_cmd_e;

    typedef enum logic [HILO_SEL_WIDTH-1:0] {
        HILO_ALU = 2'd0,
        HILO_HI  = 2'd1,
        HILO_LO  = 2'd2
    } hilo_sel_e;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_DECODE     = 3'd1,
        ST_EXECUTE    = 3'd2,
        ST_MEM_ACCESS = 3'd3,
        ST_WRITEBACK  = 3'd4,
        ST_MULT_WAIT  = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_ILLEGAL = 4'd0,
        CL_ADD     = 4'd1,
        CL_SUB     = 4'd2,
        CL_SLT     = 4'd3,
        CL_ADDI    = 4'd4,
        CL_XORI    = 4'd5,
        CL_LW      = 4'd6,
        CL_SW      = 4'd7,
        CL_BEQ     = 4'd8,
        CL_BNE     = 4'd9,
        CL_J       = 4'd10,
        CL_JAL     = 4'd11,
        CL_JR      = 4'd12,
        CL_MULT    = 4'd13,
        CL_MFHI    = 4'd14,
        CL_MFLO    = 4'd15
    } instr_class_e;

    // ALU command a class drives while it uses the ALU
    function automatic alu_cmd_e class_alu_cmd(input instr_class_e c);
        case (c)
            CL_SUB, CL_BEQ, CL_BNE: return ALU_SUB;
            CL_SLT:                 return ALU_SLT;
            CL_XORI:                return ALU_XOR;
            default:                return ALU_ADD;
        endcase
    endfunction

    // Writeback source for the HI/LO move instructions
    function automatic hilo_sel_e class_hilo_sel(input instr_class_e c);
        case (c)
            CL_MFHI: return HILO_HI;
            CL_MFLO: return HILO_LO;
            default: return HILO_ALU;
        endcase
    endfunction

    // Classes whose ALU B operand is the sign-extended immediate
    function automatic logic class_uses_imm(input instr_class_e c);
        return (c == CL_ADDI) || (c == CL_XORI) || (c == CL_LW) || (c == CL_SW);
    endfunction

    // Classes that write back to rd rather than rt
    function automatic logic class_is_rtype(input instr_class_e c);
        return (c == CL_ADD) || (c == CL_SUB) || (c == CL_SLT) ||
               (c == CL_MFHI) || (c == CL_MFLO);
    endfunction

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational opcode/funct classifier for the multicycle control unit.
module mips_instr_decode
    import mips_ctrl_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [FUNCT_WIDTH-1:0]  funct,
    output instr_class_e            instr_class,
    output logic                    illegal
);

    // Map opcode/funct pair onto an instruction class
    always_comb begin
        instr_class = CL_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  instr_class = CL_ADD;
                    FN_SUB:  instr_class = CL_SUB;
                    FN_SLT:  instr_class = CL_SLT;
                    FN_JR:   instr_class = CL_JR;
                    FN_MULT: instr_class = CL_MULT;
                    FN_MFHI: instr_class = CL_MFHI;
                    FN_MFLO: instr_class = CL_MFLO;
                    default: instr_class = CL_ILLEGAL;
                endcase
            end
            OP_LW:   instr_class = CL_LW;
            OP_SW:   instr_class = CL_SW;
            OP_BEQ:  instr_class = CL_BEQ;
            OP_BNE:  instr_class = CL_BNE;
            OP_J:    instr_class = CL_J;
            OP_JAL:  instr_class = CL_JAL;
            OP_ADDI: instr_class = CL_ADDI;
            OP_XORI: instr_class = CL_XORI;
            default: instr_class = CL_ILLEGAL;
        endcase
    end

    assign illegal = (instr_class == CL_ILLEGAL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle Moore control FSM for the lab MIPS CPU with multiplier handshake.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH   = 32,
    parameter int unsigned ALU_SEL_WIDTH = 3,
    parameter int unsigned MULT_TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [INSTR_WIDTH-1:0]   instruction,
    input  logic                     mult_done,
    output logic                     mult_start,
    output logic                     pc_write,
    output logic                     jump,
    output logic                     jr_sel,
    output logic                     jal_sel,
    output logic                     beq,
    output logic                     bne,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     mem_to_reg,
    output logic                     reg_write_en,
    output logic                     reg_dest,
    output logic                     alu_src_sel,
    output logic [ALU_SEL_WIDTH-1:0] alu_sel,
    output logic [1:0]               hilo_sel,
    output logic                     illegal,
    output logic                     mult_timeout
);

    state_e                    state_q;
    state_e                    state_d;
    logic [INSTR_WIDTH-1:0]    instr_q;
    logic [MULT_CNT_WIDTH-1:0] cnt_q;
    instr_class_e              dec_class;
    logic                      dec_illegal;
    logic                      cnt_at_limit;
    logic                      unused_instr_bits;

    // Only opcode and funct steer control; the rest of the word rides along
    assign unused_instr_bits = ^instr_q;

    assign cnt_at_limit = (cnt_q == MULT_CNT_WIDTH'(MULT_TIMEOUT - 1));

    mips_instr_decode u_decode (
        .opcode      (instr_q[31:26]),
        .funct       (instr_q[5:0]),
        .instr_class (dec_class),
        .illegal     (dec_illegal)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction latch, loaded only on an accepted handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
        end else if ((state_q == ST_FETCH) && instr_valid) begin
            instr_q <= instruction;
        end
    end

    // Multiplier wait counter: zero outside MULT_WAIT, counts cycles inside it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == ST_MULT_WAIT) begin
            cnt_q <= cnt_q + MULT_CNT_WIDTH'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (instr_valid) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = dec_illegal ? ST_FETCH : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (dec_class)
                    CL_ADD, CL_SUB, CL_SLT, CL_ADDI, CL_XORI,
                    CL_MFHI, CL_MFLO:  state_d = ST_WRITEBACK;
                    CL_LW, CL_SW:      state_d = ST_MEM_ACCESS;
                    CL_MULT:           state_d = ST_MULT_WAIT;
                    default:           state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ACCESS: begin
                state_d = (dec_class == CL_LW) ? ST_WRITEBACK : ST_FETCH;
            end
            ST_WRITEBACK: begin
                state_d = ST_FETCH;
            end
            ST_MULT_WAIT: begin
                if (mult_done || cnt_at_limit) state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Datapath strobes decoded from state and the latched instruction
    always_comb begin
        instr_ready  = 1'b0;
        mult_start   = 1'b0;
        pc_write     = 1'b0;
        jump         = 1'b0;
        jr_sel       = 1'b0;
        jal_sel      = 1'b0;
        beq          = 1'b0;
        bne          = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write_en = 1'b0;
        reg_dest     = 1'b0;
        alu_src_sel  = 1'b0;
        alu_sel      = '0;
        hilo_sel     = '0;
        illegal      = 1'b0;
        mult_timeout = 1'b0;
        case (state_q)
            ST_FETCH: begin
                instr_ready = 1'b1;
            end
            ST_DECODE: begin
                illegal = dec_illegal;
            end
            ST_EXECUTE: begin
                alu_sel     = ALU_SEL_WIDTH'(class_alu_cmd(dec_class));
                alu_src_sel = class_uses_imm(dec_class);
                hilo_sel    = class_hilo_sel(dec_class);
                case (dec_class)
                    CL_BEQ: begin
                        pc_write = 1'b1;
                        beq      = 1'b1;
                    end
                    CL_BNE: begin
                        pc_write = 1'b1;
                        bne      = 1'b1;
                    end
                    CL_J: begin
                        pc_write = 1'b1;
                        jump     = 1'b1;
                    end
                    CL_JAL: begin
                        pc_write     = 1'b1;
                        jump         = 1'b1;
                        jal_sel      = 1'b1;
                        reg_write_en = 1'b1;
                    end
                    CL_JR: begin
                        pc_write = 1'b1;
                        jump     = 1'b1;
                        jr_sel   = 1'b1;
                    end
                    CL_MULT: begin
                        mult_start = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            ST_MEM_ACCESS: begin
                if (dec_class == CL_LW) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = 1'b1;
                    pc_write  = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                reg_write_en = 1'b1;
                pc_write     = 1'b1;
                reg_dest     = class_is_rtype(dec_class);
                mem_to_reg   = (dec_class == CL_LW);
                hilo_sel     = class_hilo_sel(dec_class);
                alu_sel      = ALU_SEL_WIDTH'(class_alu_cmd(dec_class));
            end
            ST_MULT_WAIT: begin
                // A completion in the final counted cycle beats the timeout
                if (mult_done) begin
                    pc_write = 1'b1;
                end else if (cnt_at_limit) begin
                    pc_write     = 1'b1;
                    mult_timeout = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-instruction strobe schedule model.
module tb_mips_multicycle_ctrl;

    localparam int unsigned TO = 16;

    typedef struct packed {
        logic       instr_ready;
        logic       mult_start;
        logic       pc_write;
        logic       jump;
        logic       jr_sel;
        logic       jal_sel;
        logic       beq;
        logic       bne;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write_en;
        logic       reg_dest;
        logic       alu_src_sel;
        logic [2:0] alu_sel;
        logic [1:0] hilo_sel;
        logic       illegal;
        logic       mult_timeout;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        mult_done;
    logic        instr_ready, mult_start, pc_write, jump, jr_sel, jal_sel, beq, bne;
    logic        mem_read, mem_write, mem_to_reg, reg_write_en, reg_dest, alu_src_sel;
    logic [2:0]  alu_sel;
    logic [1:0]  hilo_sel;
    logic        illegal, mult_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    outs_t act;
    outs_t exp_q[$];
    outs_t cmp_e;
    outs_t trace_q[$];
    bit    done_q[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(
        .INSTR_WIDTH   (32),
        .ALU_SEL_WIDTH (3),
        .MULT_TIMEOUT  (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instruction  (instruction),
        .mult_done    (mult_done),
        .mult_start   (mult_start),
        .pc_write     (pc_write),
        .jump         (jump),
        .jr_sel       (jr_sel),
        .jal_sel      (jal_sel),
        .beq          (beq),
        .bne          (bne),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write_en (reg_write_en),
        .reg_dest     (reg_dest),
        .alu_src_sel  (alu_src_sel),
        .alu_sel      (alu_sel),
        .hilo_sel     (hilo_sel),
        .illegal      (illegal),
        .mult_timeout (mult_timeout)
    );

    // Gather DUT outputs into one comparable vector
    always_comb begin
        act              = '0;
        act.instr_ready  = instr_ready;
        act.mult_start   = mult_start;
        act.pc_write     = pc_write;
        act.jump         = jump;
        act.jr_sel       = jr_sel;
        act.jal_sel      = jal_sel;
        act.beq          = beq;
        act.bne          = bne;
        act.mem_read     = mem_read;
        act.mem_write    = mem_write;
        act.mem_to_reg   = mem_to_reg;
        act.reg_write_en = reg_write_en;
        act.reg_dest     = reg_dest;
        act.alu_src_sel  = alu_src_sel;
        act.alu_sel      = alu_sel;
        act.hilo_sel     = hilo_sel;
        act.illegal      = illegal;
        act.mult_timeout = mult_timeout;
    end

    function automatic outs_t idle();
        outs_t v;
        v = '0;
        v.instr_ready = 1'b1;
        return v;
    endfunction

    // Expected strobes for every cycle after acceptance until FETCH returns
    function automatic void build_trace(input logic [31:0] w, input int done_at, input bit early_done);
        logic [5:0] op;
        logic [5:0] fn;
        outs_t d, ex, mem, wb, v;
        bit legal, has_mem, has_wb, is_mult;
        op = w[31:26];
        fn = w[5:0];
        trace_q.delete();
        done_q.delete();
        d = '0; ex = '0; mem = '0; wb = '0;
        legal = 1'b1; has_mem = 1'b0; has_wb = 1'b0; is_mult = 1'b0;
        if (op == 6'h00) begin
            case (fn)
                6'h20: has_wb = 1'b1;
                6'h22: begin ex.alu_sel = 3'd1; has_wb = 1'b1; end
                6'h2A: begin ex.alu_sel = 3'd3; has_wb = 1'b1; end
                6'h08: begin ex.jump = 1'b1; ex.jr_sel = 1'b1; ex.pc_write = 1'b1; end
                6'h18: begin ex.mult_start = 1'b1; is_mult = 1'b1; end
                6'h10: begin ex.hilo_sel = 2'd1; has_wb = 1'b1; end
                6'h12: begin ex.hilo_sel = 2'd2; has_wb = 1'b1; end
                default: legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h23: begin
                    ex.alu_src_sel = 1'b1; has_mem = 1'b1; mem.mem_read = 1'b1;
                    has_wb = 1'b1; wb.mem_to_reg = 1'b1;
                end
                6'h2B: begin
                    ex.alu_src_sel = 1'b1; has_mem = 1'b1;
                    mem.mem_write = 1'b1; mem.pc_write = 1'b1;
                end
                6'h04: begin ex.alu_sel = 3'd1; ex.beq = 1'b1; ex.pc_write = 1'b1; end
                6'h05: begin ex.alu_sel = 3'd1; ex.bne = 1'b1; ex.pc_write = 1'b1; end
                6'h02: begin ex.jump = 1'b1; ex.pc_write = 1'b1; end
                6'h03: begin
                    ex.jump = 1'b1; ex.pc_write = 1'b1;
                    ex.jal_sel = 1'b1; ex.reg_write_en = 1'b1;
                end
                6'h08: begin ex.alu_src_sel = 1'b1; has_wb = 1'b1; end
                6'h0E: begin ex.alu_src_sel = 1'b1; ex.alu_sel = 3'd2; has_wb = 1'b1; end
                default: legal = 1'b0;
            endcase
        end
        if (has_wb) begin
            wb.reg_write_en = 1'b1;
            wb.pc_write     = 1'b1;
            wb.reg_dest     = (op == 6'h00);
            wb.hilo_sel     = ex.hilo_sel;
            wb.alu_sel      = ex.alu_sel;
        end
        d.illegal = ~legal;
        trace_q.push_back(d);
        done_q.push_back(1'b0);
        if (!legal) return;
        trace_q.push_back(ex);
        done_q.push_back(early_done);
        if (has_mem) begin trace_q.push_back(mem); done_q.push_back(1'b0); end
        if (has_wb)  begin trace_q.push_back(wb);  done_q.push_back(1'b0); end
        if (is_mult) begin
            for (int k = 1; k <= int'(TO); k++) begin
                v = '0;
                if (k == done_at) begin
                    v.pc_write = 1'b1;
                    trace_q.push_back(v);
                    done_q.push_back(1'b1);
                    break;
                end
                if (k == int'(TO)) begin
                    v.pc_write     = 1'b1;
                    v.mult_timeout = 1'b1;
                end
                trace_q.push_back(v);
                done_q.push_back(1'b0);
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive_cycle(input logic v, input logic [31:0] w, input logic d, input outs_t e);
        @(posedge clk);
        #1;
        instr_valid = v;
        instruction = w;
        mult_done   = d;
        exp_q.push_back(e);
    endtask

    // Issue one instruction, then keep junk on the bus while the FSM is busy
    task automatic run(input logic [31:0] w, input int done_at, input bit early_done);
        build_trace(w, done_at, early_done);
        drive_cycle(1'b1, w, 1'b0, idle());
        foreach (trace_q[i]) drive_cycle(1'b1, ~w ^ 32'(i), done_q[i], trace_q[i]);
    endtask

    // Per-cycle comparison of DUT outputs against the model schedule
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            n_checks++;
            if (act !== cmp_e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got %h want %h", $time, act, cmp_e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        outs_t e;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        mult_done   = 1'b0;

        // Reset holds FETCH even with a valid word offered
        drive_cycle(1'b0, 32'h0, 1'b0, idle());
        drive_cycle(1'b1, 32'h0022_1820, 1'b0, idle());
        drive_cycle(1'b0, 32'h0, 1'b0, idle());
        reset = 1'b0;
        drive_cycle(1'b0, 32'h0, 1'b0, idle());

        // ADD: 3 busy cycles, writeback to rd
        run(32'h0022_1820, 0, 1'b0);
        check("add_len", 32'(trace_q.size()), 32'd3);
        e = '0; e.reg_write_en = 1'b1; e.reg_dest = 1'b1; e.pc_write = 1'b1;
        check("add_wb", 32'(trace_q[2]), 32'(e));

        // LW: 4 busy cycles
        run(32'h8C22_0004, 0, 1'b0);
        check("lw_len", 32'(trace_q.size()), 32'd4);
        e = '0; e.mem_read = 1'b1;
        check("lw_mem", 32'(trace_q[2]), 32'(e));
        e = '0; e.reg_write_en = 1'b1; e.mem_to_reg = 1'b1; e.pc_write = 1'b1;
        check("lw_wb", 32'(trace_q[3]), 32'(e));

        // BEQ then JR: 2 busy cycles each
        run(32'h1022_0001, 0, 1'b0);
        check("beq_len", 32'(trace_q.size()), 32'd2);
        e = '0; e.beq = 1'b1; e.pc_write = 1'b1; e.alu_sel = 3'd1;
        check("beq_ex", 32'(trace_q[1]), 32'(e));
        run(32'h03E0_0008, 0, 1'b0);
        check("jr_len", 32'(trace_q.size()), 32'd2);

        // Remaining classes
        run(32'hAC22_0004, 0, 1'b0);
        check("sw_len", 32'(trace_q.size()), 32'd3);
        run(32'h1422_0001, 0, 1'b0);
        run(32'h0800_0010, 0, 1'b0);
        run(32'h0C00_0010, 0, 1'b0);
        run(32'h2022_0005, 0, 1'b0);
        run(32'h3822_0005, 0, 1'b0);
        e = '0; e.alu_src_sel = 1'b1; e.alu_sel = 3'd2;
        check("xori_ex", 32'(trace_q[1]), 32'(e));
        run(32'h0022_1822, 0, 1'b0);
        run(32'h0022_182A, 0, 1'b0);
        run(32'h0000_1810, 0, 1'b0);

        // MULT: early done in EXECUTE ignored, real done on 5th wait cycle
        run(32'h0022_0018, 5, 1'b1);
        check("mult_len", 32'(trace_q.size()), 32'd7);
        run(32'h0000_1812, 0, 1'b0);
        e = '0; e.reg_write_en = 1'b1; e.reg_dest = 1'b1; e.pc_write = 1'b1; e.hilo_sel = 2'd2;
        check("mflo_wb", 32'(trace_q[2]), 32'(e));

        // MULT timeout on the 16th wait cycle
        run(32'h0022_0018, 0, 1'b0);
        check("timeout_len", 32'(trace_q.size()), 32'd18);
        e = '0; e.pc_write = 1'b1; e.mult_timeout = 1'b1;
        check("timeout_last", 32'(trace_q[17]), 32'(e));

        // Done and timeout coincide: done wins
        run(32'h0022_0018, 16, 1'b0);
        check("tie_len", 32'(trace_q.size()), 32'd18);

        // Illegal words
        run(32'hFC00_0000, 0, 1'b0);
        check("illegal_len", 32'(trace_q.size()), 32'd1);
        run(32'h0000_0000, 0, 1'b0);
        run(32'h3422_0005, 0, 1'b0);

        // Reset in MULT_WAIT drops strobes immediately
        build_trace(32'h0022_0018, 0, 1'b0);
        drive_cycle(1'b1, 32'h0022_0018, 1'b0, idle());
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 32'h0, 1'b0, trace_q[i]);
        @(posedge clk);
        #1;
        exp_q.push_back(idle());
        #1;
        reset = 1'b1;
        #1;
        check("reset_async", 32'(act), 32'(idle()));
        drive_cycle(1'b0, 32'h0, 1'b0, idle());
        reset = 1'b0;
        drive_cycle(1'b0, 32'h0, 1'b0, idle());

        // Normal operation after the abort
        run(32'h0022_1820, 0, 1'b0);
        run(32'h0022_0018, 0, 1'b0);
        drive_cycle(1'b0, 32'h0, 1'b0, idle());
        drive_cycle(1'b0, 32'h0, 1'b0, idle());
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control unit for the lab MIPS CPU, replacing the single-cycle decode table. It latches one instruction per handshake and steps a Moore FSM through fetch, decode, execute, memory and writeback. Each state emits the datapath strobes for that step, and the FSM sequences the external multiplier with a start/done handshake and a timeout. It sits between the instruction register/PC logic and the datapath: register file, ALU, data memory, and the HI/LO multiplier.

## Interface
- `INSTR_WIDTH`, default 32: instruction word width. Must be ≥ 32; only bits [31:26] and [5:0] are decoded.
- `ALU_SEL_WIDTH`, default 3: width of `alu_sel`.
- `MULT_TIMEOUT`, default 16: maximum cycles spent in MULT_WAIT before aborting. Valid range 1..255.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `instr_valid` in 1: `instruction` holds a new word.
- `instr_ready` out 1: FSM is in FETCH and accepts a word.
- `instruction` in `INSTR_WIDTH`: instruction word.
- `mult_done` in 1: multiplier has written HI/LO.
- `mult_start` out 1: one-cycle pulse that starts the multiplier.
- `pc_write` out 1: PC update strobe.
- `jump` out 1: PC source is the jump target.
- `jr_sel` out 1: jump target is rs.
- `jal_sel` out 1: write PC+4 to $31.
- `beq` out 1: conditional PC update on ALU zero.
- `bne` out 1: conditional PC update on ALU not-zero.
- `mem_read` out 1: data memory read.
- `mem_write` out 1: data memory write.
- `mem_to_reg` out 1: writeback data comes from memory.
- `reg_write_en` out 1: register file write.
- `reg_dest` out 1: destination is rd (1) or rt (0).
- `alu_src_sel` out 1: ALU B operand is the immediate (1) or rt (0).
- `alu_sel` out `ALU_SEL_WIDTH`: ADD=0, SUB=1, XOR=2, SLT=3.
- `hilo_sel` out 2: writeback source. 0 = ALU, 1 = HI, 2 = LO.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `mult_timeout` out 1: one-cycle pulse when the multiplier wait is aborted.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM_ACCESS, WRITEBACK, MULT_WAIT.
- FETCH: `instr_ready`=1. On `instr_valid`, latch `instruction` into an internal register and go to DECODE. Otherwise stay in FETCH.
- DECODE: classify the latched word.
  - Supported opcodes: LW, SW, BEQ, BNE, J, JAL, ADDI, XORI.
  - Supported R-type functs: ADD, SUB, SLT, JR, MULT, MFHI, MFLO.
  - Anything else pulses `illegal` and returns to FETCH with no write strobes.
- EXECUTE, per instruction class:
  - R-ALU (ADD, SUB, SLT): `alu_sel` per funct, `alu_src_sel`=0. Next state WRITEBACK.
  - ADDI, XORI: `alu_src_sel`=1, `alu_sel` = ADD or XOR. Next state WRITEBACK.
  - LW, SW: `alu_sel`=ADD, `alu_src_sel`=1. Next state MEM_ACCESS.
  - BEQ, BNE: `alu_sel`=SUB, `pc_write`=1, `beq` or `bne` asserted. Next state FETCH.
  - J: `jump`=1, `pc_write`=1. Next state FETCH.
  - JAL: as J, plus `jal_sel`=1 and `reg_write_en`=1. Next state FETCH.
  - JR: `jump`=1, `jr_sel`=1, `pc_write`=1, `reg_write_en`=0. Next state FETCH.
  - MULT: `mult_start`=1. Next state MULT_WAIT.
  - MFHI, MFLO: `hilo_sel` = 1 or 2. Next state WRITEBACK.
- MEM_ACCESS:
  - LW: `mem_read`=1. Next state WRITEBACK.
  - SW: `mem_write`=1. Next state FETCH.
- WRITEBACK: `reg_write_en`=1.
  - `reg_dest`=1 for R-type, 0 for I-type.
  - `mem_to_reg`=1 only for LW.
  - `hilo_sel` held from EXECUTE.
  - Next state FETCH.
- `pc_write` is also asserted in WRITEBACK for non-branch/jump classes, and in MEM_ACCESS for SW (PC+4 path).
- MULT_WAIT: an 8-bit counter clears on entry and increments each cycle.
  - `mult_done` = 1: go to FETCH, `pc_write`=1.
  - Counter reaches `MULT_TIMEOUT`-1 without `mult_done`: pulse `mult_timeout`, `pc_write`=1, go to FETCH.
  - If both happen in the same cycle, `mult_done` wins and there is no timeout pulse.
- All outputs not listed for a state are 0.

## Timing
- Reset state: FETCH. Latched instruction = 0, counter = 0.
- Reset output values: `instr_ready`=1, all other outputs 0.
- Outputs are decoded combinationally from state and the latched instruction only, never from the live `instruction` input.
- Latency from acceptance to the next `instr_ready`:
  - branch, J, JAL, JR: 3 cycles
  - SW, R-ALU, ADDI, XORI, MFHI, MFLO: 4 cycles
  - LW: 5 cycles
  - MULT: 3 + wait cycles
- `mult_done` asserted in the same cycle as `mult_start` is ignored; it is sampled only in MULT_WAIT.
- Changes on `instruction` while not in FETCH have no effect.
- Reset mid-operation, including MULT_WAIT: return to FETCH immediately, all strobes drop asynchronously, no partial write completes.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants
  - funct constants
  - ALU command codes
  - `hilo_sel` codes
  - state enum
  - instruction-class enum
- One combinational sub-module, `mips_instr_decode`: maps opcode and funct to an instruction class plus an illegal flag. The FSM, the instruction latch and the timeout counter stay in the top module.

## Test plan
- ADD `0x00221820` -> `instr_ready` drops for 3 cycles. In WRITEBACK: `reg_write_en`=1, `reg_dest`=1, `alu_sel`=0 latched from EXECUTE. Back in FETCH on cycle 4.
- LW `0x8C220004` -> EXECUTE `alu_src_sel`=1, then MEM_ACCESS `mem_read`=1, then WRITEBACK `mem_to_reg`=1 and `reg_dest`=0. Total 5 cycles.
- BEQ `0x10220001`, then JR `0x03E00008` -> each takes 3 cycles. BEQ: `beq`=1, `alu_sel`=1. JR: `jr_sel`=1, `reg_write_en` never 1.
- MULT `0x00220018` with `mult_done` asserted 5 cycles after `mult_start` -> single `mult_start` pulse, exit on `mult_done`, no `mult_timeout`. A following MFLO `0x00001812` gives `hilo_sel`=2 in WRITEBACK.
- MULT with `mult_done` held low and `MULT_TIMEOUT`=16 -> `mult_timeout` pulses exactly once, on the 16th MULT_WAIT cycle, then FETCH.
- Illegal `0xFC000000` -> `illegal` pulses in DECODE, no write strobes. Separately, assert `reset` during MULT_WAIT -> FETCH with all outputs at reset values.
